// File: rtl/mem_port_requester_if.sv
// Request/response and cache-port bundle for one user port of the write-back cache.
// master: the requester's view. slave: the view of the load/store stage and the cache together.
interface mem_port_requester_if #(
  parameter int unsigned address_width = 26
);
  logic                     req_valid;
  logic                     req_ready;
  logic [address_width-1:0] req_addr;
  logic                     req_we;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [31:0]              req_wdata;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [31:0]              resp_rdata;
  logic [2:0]               resp_code;

  logic [address_width-1:0] mem_address;
  logic                     mem_re;
  logic                     mem_we;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_byte_mask;
  logic [6:0]               mem_status;
  logic [31:0]              mem_rdata;

  modport master (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    input  resp_ready, mem_status, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_code,
    output mem_address, mem_re, mem_we, mem_wdata, mem_byte_mask
  );

  modport slave (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    output resp_ready, mem_status, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_code,
    input  mem_address, mem_re, mem_we, mem_wdata, mem_byte_mask
  );
endinterface

// File: rtl/mem_port_requester.sv
// Single-outstanding load/store initiator for one cache user port: forms aligned address,
// byte mask and lane-shifted data, waits for a terminal status with a stall timeout.
module mem_port_requester #(
  parameter int unsigned address_width = 26,
  parameter int unsigned max_stall     = 64
) (
  input  logic                 port_clk,
  input  logic                 reset,
  mem_port_requester_if.master bus
);

  localparam int unsigned StallW = $clog2(max_stall);
  localparam logic [StallW-1:0] StallLast = StallW'(max_stall - 1);

  localparam logic [6:0] StatusReady       = 7'd0;
  localparam logic [6:0] StatusWait        = 7'd1;
  localparam logic [6:0] StatusOutOfBounds = 7'd2;
  localparam logic [6:0] StatusMisaligned  = 7'd3;
  localparam logic [6:0] StatusReadonly    = 7'd4;
  localparam logic [6:0] StatusDualWrite   = 7'd5;
  localparam logic [6:0] StatusWriteonly   = 7'd6;

  localparam logic [2:0] CodeOk          = 3'd0;
  localparam logic [2:0] CodeMisaligned  = 3'd1;
  localparam logic [2:0] CodeOutOfBounds = 3'd2;
  localparam logic [2:0] CodeReadonly    = 3'd3;
  localparam logic [2:0] CodeWriteonly   = 3'd4;
  localparam logic [2:0] CodeDualWrite   = 3'd5;
  localparam logic [2:0] CodeTimeout     = 3'd6;
  localparam logic [2:0] CodeUnknown     = 3'd7;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                   state_q;
  logic                     req_ready_q;
  logic                     resp_valid_q;
  logic [31:0]              resp_rdata_q;
  logic [2:0]               resp_code_q;
  logic                     mem_re_q;
  logic                     mem_we_q;
  logic [address_width-1:0] mem_address_q;
  logic [31:0]              mem_wdata_q;
  logic [3:0]               mem_byte_mask_q;
  logic [StallW-1:0]        stall_q;
  logic [1:0]               offset_q;
  logic [1:0]               size_q;
  logic                     unsigned_q;

  logic [1:0]  req_offset;
  logic        req_misaligned;
  logic [3:0]  req_base_mask;
  logic [31:0] load_data;
  logic [31:0] load_shifted;

  // Size 3 decodes as word everywhere, so size[1] alone selects word behaviour.
  always_comb begin
    req_offset     = bus.req_addr[1:0];
    req_misaligned = 1'b0;
    req_base_mask  = 4'b0001;
    if (bus.req_size[1]) begin
      req_misaligned = (req_offset != 2'b00);
      req_base_mask  = 4'b1111;
    end else if (bus.req_size[0]) begin
      req_misaligned = req_offset[0];
      req_base_mask  = 4'b0011;
    end
  end

  always_comb begin
    load_shifted = bus.mem_rdata >> {offset_q, 3'b000};
    load_data    = load_shifted;
    if (!size_q[1]) begin
      if (size_q[0]) begin
        load_data = {{16{load_shifted[15] & !unsigned_q}}, load_shifted[15:0]};
      end else begin
        load_data = {{24{load_shifted[7] & !unsigned_q}}, load_shifted[7:0]};
      end
    end
  end

  always_ff @(posedge port_clk) begin
    if (reset) begin
      state_q         <= StIdle;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_code_q     <= CodeOk;
      mem_re_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_address_q   <= '0;
      mem_wdata_q     <= '0;
      mem_byte_mask_q <= '0;
      stall_q         <= '0;
      offset_q        <= '0;
      size_q          <= '0;
      unsigned_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            offset_q    <= req_offset;
            size_q      <= bus.req_size;
            unsigned_q  <= bus.req_unsigned;
            if (req_misaligned) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_code_q  <= CodeMisaligned;
            end else begin
              state_q         <= StAccess;
              stall_q         <= '0;
              mem_re_q        <= !bus.req_we;
              mem_we_q        <= bus.req_we;
              mem_address_q   <= {bus.req_addr[address_width-1:2], 2'b00};
              mem_byte_mask_q <= req_base_mask << req_offset;
              mem_wdata_q     <= bus.req_wdata << {req_offset, 3'b000};
            end
          end
        end

        StAccess: begin
          if (bus.mem_status == StatusWait) begin
            if (stall_q == StallLast) begin
              state_q      <= StResp;
              mem_re_q     <= 1'b0;
              mem_we_q     <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_code_q  <= CodeTimeout;
            end else begin
              stall_q <= stall_q + StallW'(1);
            end
          end else begin
            state_q      <= StResp;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            case (bus.mem_status)
              StatusReady: begin
                resp_code_q <= CodeOk;
                if (mem_re_q) resp_rdata_q <= load_data;
              end
              StatusOutOfBounds: resp_code_q <= CodeOutOfBounds;
              StatusMisaligned:  resp_code_q <= CodeMisaligned;
              StatusReadonly:    resp_code_q <= CodeReadonly;
              StatusDualWrite:   resp_code_q <= CodeDualWrite;
              StatusWriteonly:   resp_code_q <= CodeWriteonly;
              default:           resp_code_q <= CodeUnknown;
            endcase
          end
        end

        StResp: begin
          if (bus.resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_code     = resp_code_q;
  assign bus.mem_re        = mem_re_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_byte_mask = mem_byte_mask_q;

endmodule

// File: tb/tb_mem_port_requester.sv
// Directed bench for mem_port_requester with max_stall = 4; inputs change #1 after the
// rising edge and outputs are checked at that same point.
module tb_mem_port_requester;

  localparam logic [6:0] StReady    = 7'd0;
  localparam logic [6:0] StWait     = 7'd1;
  localparam logic [6:0] StReadonly = 7'd4;

  logic port_clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  mem_port_requester_if #(.address_width(26)) bus ();

  mem_port_requester #(
    .address_width(26),
    .max_stall    (4)
  ) dut (
    .port_clk(port_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 port_clk = ~port_clk;

  task automatic tick();
    @(posedge port_clk);
    #1;
  endtask

  // Offers one request for exactly one edge; returns in the cycle after acceptance.
  task automatic issue(input logic [25:0] addr, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    bus.req_addr     = addr;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  task automatic handshake();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready);
    end
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_code !== 3'd0) begin
      failures++;
      $display("FAIL rst_resp: got v=%b d=%h c=%0d want 0/0/0",
               bus.resp_valid, bus.resp_rdata, bus.resp_code);
    end
    checks++;
    if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_address !== 26'h0 ||
        bus.mem_wdata !== 32'h0 || bus.mem_byte_mask !== 4'h0) begin
      failures++;
      $display("FAIL rst_mem: got re=%b we=%b a=%h d=%h m=%b want all 0", bus.mem_re,
               bus.mem_we, bus.mem_address, bus.mem_wdata, bus.mem_byte_mask);
    end
  endtask

  task automatic test_load_byte();
    bus.mem_status = StWait;
    issue(26'h0003, 1'b0, 2'd0, 1'b0, 32'h0);
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_address !== 26'h0) begin
      failures++;
      $display("FAIL lb_port: got re=%b we=%b a=%h want 1/0/0", bus.mem_re, bus.mem_we,
               bus.mem_address);
    end
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      failures++; $display("FAIL lb_early_resp: got %b want 0", bus.resp_valid);
    end
    bus.mem_status = StReady;
    bus.mem_rdata  = 32'h80FF_FFFF;
    tick();
    bus.mem_status = StWait;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFF_FF80 || bus.resp_code !== 3'd0) begin
      failures++;
      $display("FAIL lb_resp: got v=%b d=%h c=%0d want 1/ffffff80/0", bus.resp_valid,
               bus.resp_rdata, bus.resp_code);
    end
    checks++;
    if (bus.mem_re !== 1'b0) begin
      failures++; $display("FAIL lb_re_drop: got %b want 0", bus.mem_re);
    end
    handshake();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL lb_idle: got v=%b rdy=%b want 0/1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_store_half();
    bus.mem_status = StWait;
    bus.mem_rdata  = 32'h5555_AAAA;
    issue(26'h0006, 1'b1, 2'd1, 1'b0, 32'h0000_ABCD);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 || bus.mem_address !== 26'h4 ||
          bus.mem_byte_mask !== 4'b1100 || bus.mem_wdata !== 32'hABCD_0000) begin
        failures++;
        $display("FAIL sh_port[%0d]: got we=%b re=%b a=%h m=%b d=%h want 1/0/4/1100/abcd0000",
                 i, bus.mem_we, bus.mem_re, bus.mem_address, bus.mem_byte_mask, bus.mem_wdata);
      end
      if (i < 2) tick();
    end
    bus.mem_status = StReady;
    tick();
    bus.mem_status = StWait;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_code !== 3'd0 || bus.resp_rdata !== 32'h0 ||
        bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL sh_resp: got v=%b c=%0d d=%h we=%b want 1/0/0/0", bus.resp_valid,
               bus.resp_code, bus.resp_rdata, bus.mem_we);
    end
    handshake();
  endtask

  task automatic test_misaligned();
    issue(26'h0002, 1'b0, 2'd2, 1'b0, 32'h0);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_code !== 3'd1 || bus.resp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL mis_resp: got v=%b c=%0d d=%h want 1/1/0", bus.resp_valid,
               bus.resp_code, bus.resp_rdata);
    end
    checks++;
    if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL mis_enables: got re=%b we=%b want 0/0", bus.mem_re, bus.mem_we);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int we_cycles = 0;
    bus.mem_status = StWait;
    issue(26'h0010, 1'b1, 2'd2, 1'b0, 32'h1234_5678);
    if (bus.mem_we === 1'b1) we_cycles++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.resp_valid === 1'b1) break;
      if (bus.mem_we === 1'b1) we_cycles++;
    end
    checks++;
    if (we_cycles != 4) begin
      failures++; $display("FAIL to_we_cycles: got %0d want 4", we_cycles);
    end
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_code !== 3'd6 || bus.mem_we !== 1'b0 ||
        bus.mem_re !== 1'b0) begin
      failures++;
      $display("FAIL to_resp: got v=%b c=%0d we=%b re=%b want 1/6/0/0", bus.resp_valid,
               bus.resp_code, bus.mem_we, bus.mem_re);
    end
    handshake();
  endtask

  task automatic test_readonly_hold();
    bus.mem_status = StWait;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    issue(26'h0021, 1'b1, 2'd0, 1'b0, 32'h0000_005A);
    checks++;
    if (bus.mem_byte_mask !== 4'b0010 || bus.mem_wdata !== 32'h0000_5A00) begin
      failures++;
      $display("FAIL ro_lanes: got m=%b d=%h want 0010/00005a00", bus.mem_byte_mask,
               bus.mem_wdata);
    end
    tick();
    bus.mem_status = StReadonly;
    tick();
    bus.mem_status = StWait;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_code !== 3'd3 || bus.resp_rdata !== 32'h0 ||
          bus.req_ready !== 1'b0) begin
        failures++;
        $display("FAIL ro_hold[%0d]: got v=%b c=%0d d=%h rdy=%b want 1/3/0/0", i,
                 bus.resp_valid, bus.resp_code, bus.resp_rdata, bus.req_ready);
      end
      tick();
    end
    handshake();
  endtask

  task automatic test_load_variants();
    logic [25:0] addr [5];
    logic [1:0]  size [5];
    logic        uns  [5];
    logic [31:0] raw  [5];
    logic [31:0] exp  [5];
    addr = '{26'h42, 26'h40, 26'h45, 26'h44, 26'h4A};
    size = '{2'd1, 2'd1, 2'd0, 2'd3, 2'd1};
    uns  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    raw  = '{32'h8765_4321, 32'h8765_4321, 32'h0000_F100, 32'hDEAD_BEEF, 32'h8765_4321};
    exp  = '{32'h0000_8765, 32'h0000_4321, 32'h0000_00F1, 32'hDEAD_BEEF, 32'hFFFF_8765};
    for (int i = 0; i < 5; i++) begin
      bus.mem_status = StWait;
      issue(addr[i], 1'b0, size[i], uns[i], 32'h0);
      bus.mem_status = StReady;
      bus.mem_rdata  = raw[i];
      tick();
      bus.mem_status = StWait;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exp[i] || bus.resp_code !== 3'd0) begin
        failures++;
        $display("FAIL ld_var[%0d]: got v=%b d=%h c=%0d want 1/%h/0", i, bus.resp_valid,
                 bus.resp_rdata, bus.resp_code, exp[i]);
      end
      handshake();
    end
  endtask

  task automatic test_status_codes();
    logic [6:0] st   [5];
    logic [2:0] code [5];
    st   = '{7'd2, 7'd3, 7'd5, 7'd6, 7'h7F};
    code = '{3'd2, 3'd1, 3'd5, 3'd4, 3'd7};
    for (int i = 0; i < 5; i++) begin
      bus.mem_rdata  = 32'hCAFE_F00D;
      bus.mem_status = st[i];
      issue(26'h0080, 1'b0, 2'd2, 1'b0, 32'h0);
      tick();
      bus.mem_status = StWait;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_code !== code[i] || bus.resp_rdata !== 32'h0) begin
        failures++;
        $display("FAIL st_code[%0d]: got v=%b c=%0d d=%h want 1/%0d/0", i, bus.resp_valid,
                 bus.resp_code, bus.resp_rdata, code[i]);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    bus.mem_status = StWait;
    issue(26'h0100, 1'b0, 2'd2, 1'b0, 32'h0);
    bus.mem_status = StReady;
    bus.mem_rdata  = 32'h1111_2222;
    bus.resp_ready = 1'b1;
    bus.req_addr   = 26'h0204;
    bus.req_valid  = 1'b1;
    tick();
    bus.mem_status = StWait;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1111_2222 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_resp: got v=%b d=%h rdy=%b want 1/11112222/0", bus.resp_valid,
               bus.resp_rdata, bus.req_ready);
    end
    tick();
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_re !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got v=%b rdy=%b re=%b want 0/1/0", bus.resp_valid,
               bus.req_ready, bus.mem_re);
    end
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_address !== 26'h0204 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got re=%b a=%h rdy=%b want 1/204/0", bus.mem_re,
               bus.mem_address, bus.req_ready);
    end
    bus.mem_status = StReady;
    bus.mem_rdata  = 32'h3333_4444;
    tick();
    bus.mem_status = StWait;
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h3333_4444) begin
      failures++;
      $display("FAIL b2b_second_resp: got v=%b d=%h want 1/33334444", bus.resp_valid,
               bus.resp_rdata);
    end
    handshake();
  endtask

  task automatic test_reset_mid_access();
    bus.mem_status = StWait;
    issue(26'h0300, 1'b1, 2'd2, 1'b0, 32'hA5A5_5A5A);
    checks++;
    if (bus.mem_we !== 1'b1) begin
      failures++; $display("FAIL rma_pre: got we=%b want 1", bus.mem_we);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0 || bus.mem_address !== 26'h0 ||
        bus.mem_wdata !== 32'h0 || bus.mem_byte_mask !== 4'h0 || bus.req_ready !== 1'b1 ||
        bus.resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rma_reset: got we=%b re=%b a=%h d=%h m=%b rdy=%b v=%b want reset values",
               bus.mem_we, bus.mem_re, bus.mem_address, bus.mem_wdata, bus.mem_byte_mask,
               bus.req_ready, bus.resp_valid);
    end
    bus.mem_status = StReady;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
        failures++;
        $display("FAIL rma_no_resp[%0d]: got v=%b we=%b want 0/0", i, bus.resp_valid,
                 bus.mem_we);
      end
    end
    bus.mem_status = StWait;
  endtask

  initial begin
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_addr     = '0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;
    bus.mem_status   = StWait;
    bus.mem_rdata    = '0;

    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_readonly_hold();
    test_load_variants();
    test_status_codes();
    test_back_to_back();
    test_reset_mid_access();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_requester.md
# mem_port_requester

Initiator for one user port of the write-back cache, sitting between a RISC-V load/store stage and the cache's `address/re/we/status/rdata` port. It accepts one byte/half/word load or store at a time and forms the word-aligned address, byte mask and lane-shifted write data. It drives the cache port until the cache returns a terminal status, with a stall timeout, then returns sign/zero-extended load data or an error code.

## Interface
- `address_width`, 26: byte address width; matches the cache's address space.
- `max_stall`, 64: maximum consecutive `MEMORY_WAIT` cycles before abort; ≥ 2.
- `user_word_size` is fixed at 4 bytes.

Ports:
- `port_clk`  in  1  clock. Shared with the cache port side.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  request accepted this cycle when high with `req_valid`.
- `req_addr`  in  address_width  byte address.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- `req_unsigned`  in  1  zero-extend load, else sign-extend.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  response held until `resp_ready`.
- `resp_ready`  in  1  response consumed.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_code`  out  3  0 OK, 1 MISALIGNED, 2 OUT_OF_BOUNDS, 3 READONLY, 4 WRITEONLY, 5 DUAL_WRITE, 6 TIMEOUT, 7 UNKNOWN_STATUS.
- `mem_address`  out  address_width  word-aligned address; bits [1:0] always 0.
- `mem_re`, `mem_we`  out  1 each  one-hot enables; never both high.
- `mem_wdata`  out  32  lane-shifted store data.
- `mem_byte_mask`  out  4  write byte mask.
- `mem_status`  in  7  `memory_status_t`: READY=0, WAIT=1, OUT_OF_BOUNDS=2, MISALIGNED=3, READONLY=4, DUAL_WRITE=5, WRITEONLY=6.
- `mem_rdata`  in  32  valid in the cycle `mem_status`=READY with `mem_re` high.

## Operation
- State machine: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch the request and compute offset = `req_addr[1:0]`.
  - Misalignment: half with offset[0]=1, or word with offset≠0. Misaligned requests go to RESP with code 1 and issue no port access.
  - All other requests go to ACCESS.
- ACCESS:
  - Drive the port outputs:
    - `mem_re` = !we, `mem_we` = we.
    - `mem_address` = {addr[aw-1:2], 2'b00}.
    - `mem_byte_mask` = (byte 4'b0001, half 4'b0011, word 4'b1111) << offset.
    - `mem_wdata` = `req_wdata` << 8*offset.
  - Hold all port outputs stable every cycle in ACCESS.
  - `mem_status` handling:
    - WAIT: stay in ACCESS and increment the stall counter.
    - READY: go to RESP, code 0. For loads, capture `mem_rdata` >> 8*offset, truncated to size and extended per `req_unsigned`.
    - Codes 2–6: go to RESP with the mapped `resp_code`. DUAL_WRITE is not retried.
    - Any other value: go to RESP, code 7.
  - If the stall counter reaches `max_stall`−1 and status is still WAIT, go to RESP with code 6.
- RESP:
  - `resp_valid`=1 and all `mem_*` enables are 0.
  - On `resp_ready`, return to IDLE.
  - `req_ready` stays 0 in RESP.
- Only one transaction is outstanding; there is no pipelining across requests.

## Timing
- Reset values:
  - State IDLE; `req_ready`=1.
  - `resp_valid`=0, `resp_rdata`=0, `resp_code`=0.
  - `mem_re`=`mem_we`=0, `mem_address`=0, `mem_wdata`=0, `mem_byte_mask`=0.
  - Stall counter 0.
- Reset mid-ACCESS: enables drop in the cycle after reset is sampled and the transaction is discarded; no response is produced.
- Cycle map:
  - Accept at cycle T.
  - Port enables high T+1.
  - Status READY at T+1 gives `resp_valid` at T+2; minimum latency is 2 cycles.
  - Misaligned: `resp_valid` at T+1.
- Stall counter:
  - Width $clog2(max_stall).
  - Cleared on entry to ACCESS.
  - TIMEOUT is asserted when exactly `max_stall` consecutive WAIT cycles are observed. Enables drop the same cycle `resp_valid` rises.
- Back-to-back: `resp_ready`=1 at the first RESP cycle gives IDLE on the next cycle. The next request is accepted no earlier than 1 cycle after the response handshake.
- Status is sampled only while `mem_re` or `mem_we` is high; it is ignored in IDLE and RESP.

## Test plan
- Load byte, addr 0x0003, signed; status READY at first cycle with rdata 0x80FF_FFFF:
  - `mem_address`=0x0000, `mem_re` high.
  - `resp_rdata`=0xFFFF_FF80, code 0, latency 2.
- Store half, addr 0x0006, wdata 0x0000_ABCD:
  - `mem_address`=0x0004, mask 4'b1100, `mem_wdata`=0xABCD_0000.
  - `mem_we` held through 3 WAIT cycles, then READY gives code 0.
- Load word, addr 0x0002:
  - Response code 1 at T+1.
  - `mem_re`/`mem_we` never asserted.
- Store word, status WAIT forever, `max_stall`=4:
  - Exactly 4 cycles of `mem_we`, then code 6, enables low.
- Status sequence WAIT, READONLY on a store: code 3, `resp_rdata`=0.
- Response handling and reset:
  - Hold `resp_ready`=0 for 5 cycles: `resp_valid` and data stay stable and `req_ready` stays 0.
  - Assert reset during ACCESS: all outputs return to reset values, and no response is produced.
